alu_rs: RTL and testbench

// - ALU reservation station: receiving end of the dispatcher's ALU path (ALUen/operand/tag/op bundle).
// - Holds up to RS_DEPTH ALU ops and publishes the free root tag back to the dispatcher (ALUfreeTag).
// - Snoops the two CDBs to wake pending operands, then issues one ready op per cycle to the ALU.

---
 rtl/alu_rs_pkg.sv | 59 +++++
 rtl/alu_rs_if.sv | 40 ++++
 rtl/alu_rs_prio_enc.sv | 20 ++
 rtl/alu_rs.sv | 114 +++++++++++
 tb/tb_alu_rs.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_rs_pkg.sv
// Shared widths, tag encodings and the CDB snoop helper for the ALU reservation station.
// Optional build macro: ALU_RS_WAKEUP_BYPASS_EN (see alu_rs.sv).
package alu_rs_pkg;

    localparam int RS_DEPTH = 8;
    localparam int ROOT_W   = 3;
    localparam int TAG_W    = 4;
    localparam int DATA_W   = 32;
    localparam int OP_W     = 6;
    localparam int ADDR_W   = 32;

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [ROOT_W-1:0] root_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [OP_W-1:0]   op_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // Tags are {prefix, root}; the LS buffer never allocates root 0 under prefix 0,
    // so the all-zero tag is free to mean "operand value present".
    localparam tag_t TAG_FREE   = '0;
    localparam logic ALU_PREFIX = 1'b1;
    localparam logic ENABLE     = 1'b1;
    localparam logic DISABLE    = 1'b0;

    typedef struct packed {
        tag_t  tag;
        data_t val;
    } operand_t;

    typedef struct packed {
        logic  en;
        tag_t  tag;
        data_t data;
    } cdb_t;

    typedef struct packed {
        op_t      op;
        operand_t o;
        operand_t t;
        addr_t    addr;
        tag_t     tag_w;
    } rs_entry_t;

    function automatic operand_t snoop(input operand_t cur, input cdb_t alu, input cdb_t ls);
        operand_t res;
        res = cur;
        if (cur.tag != TAG_FREE) begin
            if (alu.en == ENABLE && alu.tag == cur.tag) begin
                res.tag = TAG_FREE;
                res.val = alu.data;
            end else if (ls.en == ENABLE && ls.tag == cur.tag) begin
                res.tag = TAG_FREE;
                res.val = ls.data;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_rs_if.sv
// Dispatcher / CDB / issue bundle of the ALU reservation station.
interface alu_rs_if
    import alu_rs_pkg::*;
();
    logic  rdy;
    logic  ALUen;
    op_t   op;
    data_t operandO;
    data_t operandT;
    tag_t  tagO;
    tag_t  tagT;
    tag_t  tagW;
    addr_t addr;
    logic  cdbAluEn;
    tag_t  cdbAluTag;
    data_t cdbAluData;
    logic  cdbLsEn;
    tag_t  cdbLsTag;
    data_t cdbLsData;
    root_t ALUfreeTag;
    logic  aluFull;
    logic  issueEn;
    op_t   issueOp;
    data_t issueA;
    data_t issueB;
    addr_t issueAddr;
    tag_t  issueTagW;

    modport master (
        output rdy, ALUen, op, operandO, operandT, tagO, tagT, tagW, addr,
               cdbAluEn, cdbAluTag, cdbAluData, cdbLsEn, cdbLsTag, cdbLsData,
        input  ALUfreeTag, aluFull, issueEn, issueOp, issueA, issueB, issueAddr, issueTagW
    );

    modport slave (
        input  rdy, ALUen, op, operandO, operandT, tagO, tagT, tagW, addr,
               cdbAluEn, cdbAluTag, cdbAluData, cdbLsEn, cdbLsTag, cdbLsData,
        output ALUfreeTag, aluFull, issueEn, issueOp, issueA, issueB, issueAddr, issueTagW
    );
endinterface

// File: rtl/alu_rs_prio_enc.sv
// Lowest-set-bit finder; used for both free-slot allocation and ready-entry select.
module alu_rs_prio_enc #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             found
);
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: dispatch into the lowest free slot, CDB wakeup, one issue per cycle.
// Optional build macro: ALU_RS_WAKEUP_BYPASS_EN lets an entry woken this cycle issue this cycle.
module alu_rs
    import alu_rs_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    alu_rs_if.slave bus
);
    rs_entry_t           ent_q [RS_DEPTH];
    rs_entry_t           ent_w [RS_DEPTH];
    rs_entry_t           new_ent;
    logic [RS_DEPTH-1:0] valid_q;
    logic [RS_DEPTH-1:0] ready_vec;
    root_t               free_idx;
    root_t               sel_idx;
    logic                free_found;
    logic                sel_found;
    logic                dispatch;
    cdb_t                cdb_alu;
    cdb_t                cdb_ls;

    logic                issue_en_q;
    op_t                 issue_op_q;
    data_t               issue_a_q;
    data_t               issue_b_q;
    addr_t               issue_addr_q;
    tag_t                issue_tag_w_q;

    assign cdb_alu = '{en: bus.cdbAluEn, tag: bus.cdbAluTag, data: bus.cdbAluData};
    assign cdb_ls  = '{en: bus.cdbLsEn,  tag: bus.cdbLsTag,  data: bus.cdbLsData};

    alu_rs_prio_enc #(.N(RS_DEPTH)) u_free_enc (
        .req   (~valid_q),
        .idx   (free_idx),
        .found (free_found)
    );

    alu_rs_prio_enc #(.N(RS_DEPTH)) u_sel_enc (
        .req   (ready_vec),
        .idx   (sel_idx),
        .found (sel_found)
    );

    assign dispatch = bus.ALUen && free_found && bus.rdy;

    // An operand whose producer broadcasts in the dispatch cycle would otherwise miss it forever.
    always_comb begin
        new_ent.op    = bus.op;
        new_ent.o     = snoop(operand_t'{tag: bus.tagO, val: bus.operandO}, cdb_alu, cdb_ls);
        new_ent.t     = snoop(operand_t'{tag: bus.tagT, val: bus.operandT}, cdb_alu, cdb_ls);
        new_ent.addr  = bus.addr;
        new_ent.tag_w = bus.tagW;
    end

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            ent_w[i]   = ent_q[i];
            ent_w[i].o = snoop(ent_q[i].o, cdb_alu, cdb_ls);
            ent_w[i].t = snoop(ent_q[i].t, cdb_alu, cdb_ls);
`ifdef ALU_RS_WAKEUP_BYPASS_EN
            ready_vec[i] = valid_q[i] && ent_w[i].o.tag == TAG_FREE && ent_w[i].t.tag == TAG_FREE;
`else
            ready_vec[i] = valid_q[i] && ent_q[i].o.tag == TAG_FREE && ent_q[i].t.tag == TAG_FREE;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= '0;
            issue_en_q    <= 1'b0;
            issue_op_q    <= '0;
            issue_a_q     <= '0;
            issue_b_q     <= '0;
            issue_addr_q  <= '0;
            issue_tag_w_q <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else if (bus.rdy) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_q[i] <= ent_w[i];
            end
            // Dispatch only targets an empty slot and select only a valid one, so they never collide.
            if (sel_found) begin
                valid_q[sel_idx] <= 1'b0;
            end
            if (dispatch) begin
                valid_q[free_idx] <= 1'b1;
                ent_q[free_idx]   <= new_ent;
            end
            issue_en_q <= sel_found;
            if (sel_found) begin
                issue_op_q    <= ent_w[sel_idx].op;
                issue_a_q     <= ent_w[sel_idx].o.val;
                issue_b_q     <= ent_w[sel_idx].t.val;
                issue_addr_q  <= ent_w[sel_idx].addr;
                issue_tag_w_q <= ent_w[sel_idx].tag_w;
            end
        end else begin
            issue_en_q <= 1'b0;
        end
    end

    assign bus.ALUfreeTag = free_idx;
    assign bus.aluFull    = ~free_found;
    assign bus.issueEn    = issue_en_q;
    assign bus.issueOp    = issue_op_q;
    assign bus.issueA     = issue_a_q;
    assign bus.issueB     = issue_b_q;
    assign bus.issueAddr  = issue_addr_q;
    assign bus.issueTagW  = issue_tag_w_q;
endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: table-driven dispatch/issue plus wakeup, full, order, freeze and reset sequences.
module tb_alu_rs;
    import alu_rs_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_rs_if bus ();

    alu_rs dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        op_t   op;
        data_t a;
        data_t b;
        tag_t  tw;
        addr_t ad;
    } vec_t;

    vec_t vecs [4];
    tag_t ord_tag [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_disp(input logic en, input op_t op, input tag_t to, input data_t vo,
                              input tag_t tt, input data_t vt, input tag_t tw, input addr_t ad);
        bus.ALUen    = en;
        bus.op       = op;
        bus.tagO     = to;
        bus.operandO = vo;
        bus.tagT     = tt;
        bus.operandT = vt;
        bus.tagW     = tw;
        bus.addr     = ad;
    endtask

    task automatic set_cdb(input logic ae, input tag_t at, input data_t ad,
                           input logic le, input tag_t lt, input data_t ld);
        bus.cdbAluEn   = ae;
        bus.cdbAluTag  = at;
        bus.cdbAluData = ad;
        bus.cdbLsEn    = le;
        bus.cdbLsTag   = lt;
        bus.cdbLsData  = ld;
    endtask

    task automatic idle_disp();
        drive_disp(1'b0, '0, TAG_FREE, '0, TAG_FREE, '0, '0, '0);
    endtask

    task automatic idle_cdb();
        set_cdb(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Called just after the edge that carried the waking CDB, with the CDB already dropped.
    task automatic after_wake();
`ifndef ALU_RS_WAKEUP_BYPASS_EN
        chk("wake_one_cycle_later", bus.issueEn, 0);
        tick();
`endif
    endtask

    initial begin
        vecs[0] = '{op: 6'h01, a: 32'd5,          b: 32'd7,          tw: 4'h8, ad: 32'h0000_1000};
        vecs[1] = '{op: 6'h02, a: 32'hFFFF_FFFF,  b: 32'd1,          tw: 4'h9, ad: 32'h0000_2004};
        vecs[2] = '{op: 6'h3F, a: 32'd0,          b: 32'h8000_0000,  tw: 4'hF, ad: 32'hFFFF_FFFC};
        vecs[3] = '{op: 6'h00, a: 32'hA5A5_A5A5,  b: 32'h5A5A_5A5A,  tw: 4'hA, ad: 32'h0000_0000};
        ord_tag[0] = 4'hD; ord_tag[1] = 4'hC; ord_tag[2] = 4'hD; ord_tag[3] = 4'hD; ord_tag[4] = 4'hC;

        bus.rdy = 1'b1;
        idle_disp();
        idle_cdb();

        #23;
        chk("rst_issueEn", bus.issueEn, 0);
        chk("rst_freeTag", bus.ALUfreeTag, 0);
        chk("rst_aluFull", bus.aluFull, 0);
        chk("rst_issueA", bus.issueA, 0);
        chk("rst_issueTagW", bus.issueTagW, 0);
        rst = 1'b0;
        tick();

        // Ready-operand dispatch: issue one edge after the dispatch edge.
        for (int i = 0; i < 4; i++) begin
            drive_disp(1'b1, vecs[i].op, TAG_FREE, vecs[i].a, TAG_FREE, vecs[i].b, vecs[i].tw, vecs[i].ad);
            chk("vec_free_pre", bus.ALUfreeTag, 0);
            tick();
            idle_disp();
            chk("vec_free_post", bus.ALUfreeTag, 1);
            chk("vec_no_early_issue", bus.issueEn, 0);
            tick();
            chk("vec_issueEn", bus.issueEn, 1);
            chk("vec_issueOp", bus.issueOp, vecs[i].op);
            chk("vec_issueA", bus.issueA, vecs[i].a);
            chk("vec_issueB", bus.issueB, vecs[i].b);
            chk("vec_issueTagW", bus.issueTagW, vecs[i].tw);
            chk("vec_issueAddr", bus.issueAddr, vecs[i].ad);
            chk("vec_free_after_issue", bus.ALUfreeTag, 0);
            tick();
            chk("vec_idle", bus.issueEn, 0);
        end

        // Pending O operand woken by the ALU CDB; a non-matching broadcast first.
        drive_disp(1'b1, 6'h05, 4'h3, 32'hDEAD_BEEF, TAG_FREE, 32'd7, 4'hB, 32'h40);
        tick();
        idle_disp();
        set_cdb(1'b1, 4'h4, 32'hBAD, 1'b0, '0, '0);
        tick();
        idle_cdb();
        chk("wrong_tag_no_issue", bus.issueEn, 0);
        set_cdb(1'b1, 4'h3, 32'h1234, 1'b0, '0, '0);
        tick();
        idle_cdb();
        after_wake();
        chk("wake_issueEn", bus.issueEn, 1);
        chk("wake_issueA", bus.issueA, 32'h1234);
        chk("wake_issueB", bus.issueB, 7);
        chk("wake_issueTagW", bus.issueTagW, 4'hB);
        tick();
        chk("wake_idle", bus.issueEn, 0);

        // Producer broadcasts on the LS CDB in the dispatch cycle.
        drive_disp(1'b1, 6'h06, 4'h5, 32'hDEAD, TAG_FREE, 32'd3, 4'hC, 32'h0);
        set_cdb(1'b0, '0, '0, 1'b1, 4'h5, 32'd9);
        tick();
        idle_disp();
        idle_cdb();
        tick();
        chk("capture_issueEn", bus.issueEn, 1);
        chk("capture_issueA", bus.issueA, 9);
        chk("capture_issueB", bus.issueB, 3);
        tick();

        // Both operands woken by different CDBs in one cycle.
        drive_disp(1'b1, 6'h07, 4'h3, 32'h0, 4'h5, 32'h0, 4'hD, 32'h0);
        tick();
        idle_disp();
        set_cdb(1'b1, 4'h3, 32'h11, 1'b1, 4'h5, 32'h22);
        tick();
        idle_cdb();
        after_wake();
        chk("dual_issueEn", bus.issueEn, 1);
        chk("dual_issueA", bus.issueA, 32'h11);
        chk("dual_issueB", bus.issueB, 32'h22);
        tick();

        // Fill all eight slots with pending entries.
        for (int i = 0; i < 8; i++) begin
            chk("fill_freeTag", bus.ALUfreeTag, i);
            drive_disp(1'b1, op_t'(i), tag_t'(8 + i), '0, TAG_FREE, data_t'(i), tag_t'(8 + i), addr_t'(i * 4));
            tick();
        end
        idle_disp();
        chk("fill_aluFull", bus.aluFull, 1);
        drive_disp(1'b1, 6'h3E, TAG_FREE, 32'hEEEE, TAG_FREE, 32'hEEEE, 4'h3, 32'h0);
        tick();
        idle_disp();
        tick();
        chk("full_dispatch_ignored", bus.issueEn, 0);
        chk("full_still_full", bus.aluFull, 1);
        set_cdb(1'b1, 4'hA, 32'h2222, 1'b0, '0, '0);
        chk("full_before_wake_edge", bus.aluFull, 1);
        tick();
        idle_cdb();
        after_wake();
        chk("full_wake_issueEn", bus.issueEn, 1);
        chk("full_wake_issueOp", bus.issueOp, 2);
        chk("full_wake_issueA", bus.issueA, 32'h2222);
        chk("full_wake_issueB", bus.issueB, 2);
        chk("full_wake_issueTagW", bus.issueTagW, 4'hA);
        chk("full_wake_freeTag", bus.ALUfreeTag, 2);
        chk("full_wake_aluFull", bus.aluFull, 0);

        // Asynchronous reset between edges with seven valid entries.
        #2 rst = 1'b1;
        #1;
        chk("async_rst_issueEn", bus.issueEn, 0);
        chk("async_rst_aluFull", bus.aluFull, 0);
        chk("async_rst_freeTag", bus.ALUfreeTag, 0);
        #2 rst = 1'b0;
        tick();
        set_cdb(1'b1, 4'h8, 32'h8888, 1'b0, '0, '0);
        tick();
        idle_cdb();
        chk("rst_dropped_a", bus.issueEn, 0);
        tick();
        chk("rst_dropped_b", bus.issueEn, 0);

        // Entries 1 and 4 wake together; freeze for three cycles after the first issue.
        for (int i = 0; i < 5; i++) begin
            drive_disp(1'b1, 6'h10, ord_tag[i], '0, TAG_FREE, data_t'(i), tag_t'(8 + i), '0);
            tick();
        end
        idle_disp();
        set_cdb(1'b1, 4'hC, 32'h55, 1'b0, '0, '0);
        tick();
        idle_cdb();
        after_wake();
        chk("order_first_en", bus.issueEn, 1);
        chk("order_first_is_e1", bus.issueB, 1);
        chk("order_first_tagW", bus.issueTagW, 4'h9);
        bus.rdy = 1'b0;
        drive_disp(1'b1, 6'h11, TAG_FREE, 32'h99, TAG_FREE, 32'h99, 4'h3, '0);
        set_cdb(1'b1, 4'hD, 32'h66, 1'b0, '0, '0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("freeze_issueEn", bus.issueEn, 0);
            chk("freeze_freeTag", bus.ALUfreeTag, 1);
            chk("freeze_aluFull", bus.aluFull, 0);
        end
        bus.rdy = 1'b1;
        idle_disp();
        idle_cdb();
        tick();
        chk("resume_issueEn", bus.issueEn, 1);
        chk("resume_is_e4", bus.issueB, 4);
        chk("resume_issueA", bus.issueA, 32'h55);
        chk("resume_freeTag", bus.ALUfreeTag, 1);
        tick();
        chk("freeze_cdb_ignored", bus.issueEn, 0);
        set_cdb(1'b1, 4'hD, 32'h77, 1'b0, '0, '0);
        tick();
        idle_cdb();
        after_wake();
        chk("drain_e0_en", bus.issueEn, 1);
        chk("drain_e0_B", bus.issueB, 0);
        chk("drain_e0_A", bus.issueA, 32'h77);
        tick();
        chk("drain_e2_B", bus.issueB, 2);
        tick();
        chk("drain_e3_B", bus.issueB, 3);
        chk("drain_e3_en", bus.issueEn, 1);
        tick();
        chk("drain_idle", bus.issueEn, 0);
        chk("drain_freeTag", bus.ALUfreeTag, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
